collision_reader: RTL and testbench
===================================

Name: collision_reader

Overview:
- Port-B client of the 1Kx9 collision buffer; the sprite renderer writes the buffer through port A.
- After a line or frame is rendered, scans the buffer from address 0 upward.
- Each entry with the collision flag set is emitted as a record (address, object id) over a valid/ready handshake into the collision register file.
- Each visited entry is optionally cleared, so the buffer is zeroed for the next pass.

Parameters:
- ADDR_WIDTH, 10, buffer address width (buffer depth 2^ADDR_WIDTH).
- DATA_WIDTH, 9, buffer word width. Bit DATA_WIDTH-1 is the collision flag; bits DATA_WIDTH-2:0 are the object id.
- COUNT_WIDTH, 8, width of the saturating collision counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle scan request; ignored while busy.
- scan_len  input  ADDR_WIDTH+1  number of entries to scan; latched at start.
- clear_en  input  1  clear visited entries; latched at start.
- busy  output  1  scan in progress.
- done  output  1  one-cycle pulse at scan end.
- mem_wr  output  1  buffer port-B write enable.
- mem_addr  output  ADDR_WIDTH  buffer port-B address.
- mem_wr_data  output  DATA_WIDTH  buffer port-B write data; always 0.
- mem_rd_data  input  DATA_WIDTH  buffer port-B read data; valid the cycle after the address is presented.
- coll_valid  output  1  collision record valid.
- coll_ready  input  1  downstream accepts record.
- coll_addr  output  ADDR_WIDTH  buffer address of the record.
- coll_id  output  DATA_WIDTH-1  object id of the record.
- coll_count  output  COUNT_WIDTH  records accepted during the current or last scan.

Behaviour:
- Reset values: state IDLE, busy=0, done=0, mem_wr=0, mem_addr=0, mem_wr_data=0, coll_valid=0, coll_addr=0, coll_id=0, coll_count=0.
- Reset mid-scan: abort immediately. Buffer is left partially cleared; software reruns the scan.
- States:
  - IDLE: start=1 latches len=min(scan_len, 2^ADDR_WIDTH) and clear_en, zeroes coll_count and the index. Next state is DONE if len=0, else READ.
  - READ: mem_addr=index, mem_wr=0. Next state EVAL.
  - EVAL: mem_rd_data holds the entry; mem_addr=index; mem_wr=clear_en; mem_wr_data=0.
    - Flag bit set: capture coll_addr=index and coll_id=low bits, go to EMIT.
    - Flag clear: if index=len-1, go to DONE; else index+1 and go to READ.
  - EMIT: coll_valid=1; coll_addr and coll_id held stable; mem_wr=0. Stays in EMIT until coll_ready=1.
    - On acceptance: coll_count += 1, saturating at all-ones.
    - Then: if index=len-1, go to DONE; else index+1 and go to READ.
    - The cycle after acceptance, coll_valid=0.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy is 1 in READ, EVAL, EMIT and DONE.
- Outputs are functions of registered state only. coll_ready does not combinationally affect any output in the same cycle.
- Cycle counts:
  - Clean entry: 2 cycles.
  - Flagged entry: 3 cycles plus downstream stall cycles.
  - Full clean 1024-entry scan: start at cycle T, done at cycle T+2049.
- Index arithmetic is ADDR_WIDTH bits. The last index is 2^ADDR_WIDTH-1 and never wraps, because termination is checked before increment.
- Entries with a nonzero id and flag clear are cleared (if clear_en) but not reported.
- start is ignored while busy is 1.
- Port arbitration: mem_wr pulses only in EVAL.
  - Concurrent port-A writes to a different address are legal.
  - A same-address write on both ports in the same cycle is undefined. The renderer must not run during a scan.
- coll_count holds its value after done until the next start.

Test Plan:
- Reset during EMIT with coll_valid=1 -> next cycle busy=0, coll_valid=0, mem_wr=0, coll_count=0; a new start works normally.
- Buffer all zero, scan_len=1024, clear_en=1, start at cycle T:
  - mem_wr pulses 1024 times at addresses 0..1023.
  - done=1 only at T+2049; coll_count=0; coll_valid never asserted.
- Entries: [5]=0x103, [1023]=0x1FF, [7]=0x044 (flag clear); coll_ready=1; clear_en=1:
  - Exactly two records, (5, 0x03) then (1023, 0xFF); coll_count=2.
  - Readback of all three entries is 0.
- Same fill with coll_ready held low 10 cycles during the first record:
  - coll_valid, coll_addr=5 and coll_id=0x03 are stable for all 10 cycles.
  - Record is accepted exactly once; no address is skipped.
- scan_len=0 with start at T -> busy=1 and done=1 at T+1 only; no memory access.
- scan_len=2000 -> clamped to 1024 entries.
- clear_en=0 -> mem_wr never 1 and contents are unchanged.
- 300 flagged entries, COUNT_WIDTH=8 -> coll_count saturates at 255.
- start pulsed while busy -> ignored; the scan is unaffected.

Source files
------------

// File: rtl/collision_reader_if.sv
// ---------------------------------------------------------------------------
// collision_reader_if
//
// Bundles the two buses the collision reader talks on:
//   - port B of the 1Kx9 collision buffer (address, write enable, write data,
//     registered read data that arrives one cycle after the address)
//   - the collision record stream into the collision register file
//     (valid/ready handshake carrying buffer address and object id)
//
// Modports:
//   master : the collision reader (drives the buffer port and the records)
//   slave  : the buffer/register-file side (returns read data and ready)
// ---------------------------------------------------------------------------
interface collision_reader_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 9
);

   logic                  mem_wr;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wr_data;
   logic [DATA_WIDTH-1:0] mem_rd_data;

   logic                  coll_valid;
   logic                  coll_ready;
   logic [ADDR_WIDTH-1:0] coll_addr;
   logic [DATA_WIDTH-2:0] coll_id;

   modport master (
      output mem_wr,
      output mem_addr,
      output mem_wr_data,
      input  mem_rd_data,
      output coll_valid,
      input  coll_ready,
      output coll_addr,
      output coll_id
   );

   modport slave (
      input  mem_wr,
      input  mem_addr,
      input  mem_wr_data,
      output mem_rd_data,
      input  coll_valid,
      output coll_ready,
      input  coll_addr,
      input  coll_id
   );

endinterface

// File: rtl/collision_reader.sv
// ---------------------------------------------------------------------------
// collision_reader
//
// Port-B client of the collision buffer. After the sprite renderer has filled
// the buffer, a start pulse makes this block walk the buffer from address 0
// upward. Every entry whose top bit (collision flag) is set is handed to the
// collision register file as an (address, object id) record over a
// valid/ready handshake. Optionally every visited entry is written back to
// zero so the buffer is clean for the next line/frame.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset; aborts a scan in progress
//   start       one-cycle scan request, ignored while busy
//   scan_len    number of entries to scan (clamped to the buffer depth),
//               latched at start
//   clear_en    zero each visited entry, latched at start
//   busy        scan in progress
//   done        one-cycle pulse when the scan finishes
//   bus         buffer port B and collision record stream (master side)
//   coll_count  saturating count of records accepted in the current/last scan
// ---------------------------------------------------------------------------
module collision_reader #(
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 9,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [ADDR_WIDTH:0]    scan_len,
   input  logic                   clear_en,
   output logic                   busy,
   output logic                   done,
   collision_reader_if.master     bus,
   output logic [COUNT_WIDTH-1:0] coll_count
);

   localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH-1:0] IDX_ONE = ADDR_WIDTH'(1);
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      EVAL = 3'd2,
      EMIT = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t                 state;
   state_t                 state_next;

   logic [ADDR_WIDTH-1:0]  index;
   logic [ADDR_WIDTH-1:0]  index_next;
   logic [ADDR_WIDTH-1:0]  last_index;
   logic [ADDR_WIDTH-1:0]  last_index_next;
   logic                   clear_q;
   logic                   clear_next;
   logic [ADDR_WIDTH-1:0]  coll_addr_q;
   logic [ADDR_WIDTH-1:0]  coll_addr_next;
   logic [DATA_WIDTH-2:0]  coll_id_q;
   logic [DATA_WIDTH-2:0]  coll_id_next;
   logic [COUNT_WIDTH-1:0] count_q;
   logic [COUNT_WIDTH-1:0] count_next;

   logic                   len_zero;
   logic [ADDR_WIDTH-1:0]  last_from_len;
   logic                   entry_flag;
   logic [DATA_WIDTH-2:0]  entry_id;
   logic                   at_last;
   logic                   count_full;

   // The scan length is kept as the index of the last entry rather than as a
   // count. That fits in ADDR_WIDTH bits even for a full-depth scan, and lets
   // the walk stop on index == last_index before the index is incremented, so
   // the index never has to wrap past the top of the buffer. Requests larger
   // than the buffer are clamped to the whole buffer.
   always_comb begin
      len_zero = (scan_len == '0);
      if (scan_len >= DEPTH) begin
         last_from_len = '1;
      end else begin
         last_from_len = scan_len[ADDR_WIDTH-1:0] - IDX_ONE;
      end
   end

   // Field split of the buffer word returned on port B, plus the two
   // termination/saturation conditions used by the sequencer.
   always_comb begin
      entry_flag = bus.mem_rd_data[DATA_WIDTH-1];
      entry_id   = bus.mem_rd_data[DATA_WIDTH-2:0];
      at_last    = (index == last_index);
      count_full = &count_q;
   end

   // State and datapath registers. Reset abandons any scan in flight; the
   // buffer may then be only partly cleared, which software handles by
   // simply running the scan again.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         index       <= '0;
         last_index  <= '0;
         clear_q     <= 1'b0;
         coll_addr_q <= '0;
         coll_id_q   <= '0;
         count_q     <= '0;
      end else begin
         state       <= state_next;
         index       <= index_next;
         last_index  <= last_index_next;
         clear_q     <= clear_next;
         coll_addr_q <= coll_addr_next;
         coll_id_q   <= coll_id_next;
         count_q     <= count_next;
      end
   end

   // Scan sequencer. Each clean entry takes READ (address out) then EVAL
   // (data back, optional clear). A flagged entry adds an EMIT phase that
   // waits for the register file to take the record; the record fields are
   // captured in EVAL so they stay frozen however long the stall lasts.
   // coll_ready only influences what happens at the next edge, never the
   // outputs of the current cycle.
   always_comb begin
      state_next      = state;
      index_next      = index;
      last_index_next = last_index;
      clear_next      = clear_q;
      coll_addr_next  = coll_addr_q;
      coll_id_next    = coll_id_q;
      count_next      = count_q;

      unique case (state)
         IDLE: begin
            if (start) begin
               last_index_next = last_from_len;
               clear_next      = clear_en;
               count_next      = '0;
               index_next      = '0;
               if (len_zero) begin
                  state_next = DONE;
               end else begin
                  state_next = READ;
               end
            end
         end

         READ: begin
            state_next = EVAL;
         end

         EVAL: begin
            if (entry_flag) begin
               coll_addr_next = index;
               coll_id_next   = entry_id;
               state_next     = EMIT;
            end else if (at_last) begin
               state_next = DONE;
            end else begin
               index_next = index + IDX_ONE;
               state_next = READ;
            end
         end

         EMIT: begin
            if (bus.coll_ready) begin
               if (!count_full) begin
                  count_next = count_q + CNT_ONE;
               end
               if (at_last) begin
                  state_next = DONE;
               end else begin
                  index_next = index + IDX_ONE;
                  state_next = READ;
               end
            end
         end

         DONE: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs are decoded purely from registered state. Port B only writes in
   // EVAL, the single cycle per entry in which the entry is being looked at,
   // and the write data is always zero because clearing is its only purpose.
   always_comb begin
      busy            = (state != IDLE);
      done            = (state == DONE);
      bus.mem_addr    = index;
      bus.mem_wr      = (state == EVAL) && clear_q;
      bus.mem_wr_data = '0;
      bus.coll_valid  = (state == EMIT);
      bus.coll_addr   = coll_addr_q;
      bus.coll_id     = coll_id_q;
      coll_count      = count_q;
   end

endmodule

// File: tb/tb_collision_reader.sv
// ---------------------------------------------------------------------------
// tb_collision_reader
//
// Drives collision_reader against a behavioural 1Kx9 buffer and a randomly
// or deliberately stalling record sink. Expected records, final buffer image,
// write count, counter value and scan duration come from a simple list-based
// model of the scan rules built when each scan starts.
// ---------------------------------------------------------------------------
module tb_collision_reader;

   localparam int AW    = 10;
   localparam int DW    = 9;
   localparam int CW    = 8;
   localparam int DEPTH = 1 << AW;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW:0]   scan_len;
   logic          clear_en;
   logic          busy;
   logic          done;
   logic [CW-1:0] coll_count;

   collision_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   collision_reader #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .COUNT_WIDTH(CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .scan_len  (scan_len),
      .clear_en  (clear_en),
      .busy      (busy),
      .done      (done),
      .bus       (bus.master),
      .coll_count(coll_count)
   );

   // Free-running clock and a cycle counter used to time-stamp events.
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural collision buffer. Port A stands in for the renderer (single
   // writes plus a bulk clear); port B is the DUT with registered read data.
   logic [DW-1:0] mem [DEPTH];
   logic          pa_we;
   logic          pa_clr;
   logic [AW-1:0] pa_addr;
   logic [DW-1:0] pa_data;

   always @(posedge clk) begin
      if (pa_clr) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (pa_we) begin
         mem[pa_addr] <= pa_data;
      end
      if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wr_data;
      bus.mem_rd_data <= mem[bus.mem_addr];
   end

   // Record sink: either a fixed ready level chosen by the sequence below or
   // a random 75%-ready pattern, changed just after each rising edge.
   int   ready_mode;
   logic ready_fixed;

   initial begin
      bus.coll_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode == 1) bus.coll_ready = ($urandom_range(0, 3) != 0);
         else                 bus.coll_ready = ready_fixed;
      end
   end

   // Passive observer, sampling on the falling edge. Everything is kept as
   // running totals; each scan remembers where the totals stood at its start.
   logic [AW-1:0]      wr_q [$];
   logic [AW+DW-2:0]   rec_q [$];
   int                 wdata_err_total    = 0;
   int                 valid_total        = 0;
   int                 stall_total        = 0;
   int                 stab_err_total     = 0;
   int                 done_total         = 0;
   int                 done_nobusy_total  = 0;
   int                 done_cyc           = 0;
   logic               prev_stall         = 1'b0;
   logic [AW-1:0]      prev_addr          = '0;
   logic [DW-2:0]      prev_id            = '0;

   always @(negedge clk) begin
      if (reset) begin
         prev_stall <= 1'b0;
      end else begin
         if (bus.mem_wr) begin
            wr_q.push_back(bus.mem_addr);
            if (bus.mem_wr_data !== '0) wdata_err_total <= wdata_err_total + 1;
         end
         if (bus.coll_valid) valid_total <= valid_total + 1;
         if (prev_stall && (bus.coll_valid !== 1'b1 || bus.coll_addr !== prev_addr ||
                            bus.coll_id !== prev_id))
            stab_err_total <= stab_err_total + 1;
         prev_stall <= bus.coll_valid && !bus.coll_ready;
         if (bus.coll_valid && !bus.coll_ready) stall_total <= stall_total + 1;
         prev_addr <= bus.coll_addr;
         prev_id   <= bus.coll_id;
         if (bus.coll_valid && bus.coll_ready) rec_q.push_back({bus.coll_addr, bus.coll_id});
         if (done) begin
            done_total <= done_total + 1;
            done_cyc   <= cyc;
            if (!busy) done_nobusy_total <= done_nobusy_total + 1;
         end
      end
   end

   int checks = 0;
   int errors = 0;

   // Reference model state for the scan in progress.
   logic [AW+DW-2:0] exp_rec [$];
   logic [DW-1:0]    exp_img [DEPTH];
   int               exp_len;
   int               exp_writes;
   int               t_start;
   int               wr_base, rec_base, wdata_base, valid_base, stall_base;
   int               stab_base, done_base, nobusy_base;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic fillEntry(input int addr, input logic [DW-1:0] data);
      pa_addr = AW'(addr);
      pa_data = data;
      pa_we   = 1'b1;
      @(posedge clk);
      #1;
      pa_we   = 1'b0;
   endtask

   task automatic clearBuffer();
      pa_clr = 1'b1;
      @(posedge clk);
      #1;
      pa_clr = 1'b0;
   endtask

   task automatic fillRandom(input int n);
      for (int i = 0; i < n; i++) fillEntry($urandom_range(0, DEPTH - 1), DW'($urandom));
   endtask

   // The scan, stated plainly: the first min(len, depth) entries are visited
   // in address order, flagged ones become records, and with clearing on
   // every visited entry ends up zero.
   task automatic buildModel(input int len_req, input logic clr);
      exp_len = (len_req > DEPTH) ? DEPTH : len_req;
      exp_rec.delete();
      for (int i = 0; i < DEPTH; i++) exp_img[i] = mem[i];
      for (int i = 0; i < exp_len; i++) begin
         if (mem[i][DW-1]) exp_rec.push_back({AW'(i), mem[i][DW-2:0]});
         if (clr) exp_img[i] = '0;
      end
      exp_writes = clr ? exp_len : 0;
   endtask

   task automatic applyStimulus(input int len_req, input logic clr);
      buildModel(len_req, clr);
      wr_base     = wr_q.size();
      rec_base    = rec_q.size();
      wdata_base  = wdata_err_total;
      valid_base  = valid_total;
      stall_base  = stall_total;
      stab_base   = stab_err_total;
      done_base   = done_total;
      nobusy_base = done_nobusy_total;
      scan_len    = (AW + 1)'(len_req);
      clear_en    = clr;
      start       = 1'b1;
      t_start     = cyc;
      @(posedge clk);
      #1;
      start       = 1'b0;
      scan_len    = (AW + 1)'($urandom);
      clear_en    = ~clr;
   endtask

   task automatic waitDone(input string name, input int budget);
      logic got = 1'b0;
      for (int n = 0; n < budget && !got; n++) begin
         @(negedge clk);
         if (done === 1'b1) got = 1'b1;
      end
      checkOutput({name, ".done_seen"}, got, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic checkScan(input string name);
      int n_exp;
      int n_obs;
      int mism;
      int expected_cycles;
      n_exp = exp_rec.size();
      n_obs = rec_q.size() - rec_base;
      checkOutput({name, ".done_pulses"}, done_total - done_base, 1);
      expected_cycles = t_start + 1 + 2 * exp_len + n_exp + (stall_total - stall_base);
      checkOutput({name, ".done_cycle"}, done_cyc, expected_cycles);
      checkOutput({name, ".done_busy"}, done_nobusy_total - nobusy_base, 0);
      checkOutput({name, ".idle_busy"}, busy, 0);
      checkOutput({name, ".rec_count"}, n_obs, n_exp);
      mism = 0;
      for (int i = 0; i < n_exp; i++)
         if (rec_base + i >= rec_q.size() || rec_q[rec_base + i] !== exp_rec[i]) mism++;
      checkOutput({name, ".rec_data"}, mism, 0);
      checkOutput({name, ".coll_count"}, coll_count, (n_exp > CMAX) ? CMAX : n_exp);
      checkOutput({name, ".wr_count"}, wr_q.size() - wr_base, exp_writes);
      mism = 0;
      for (int i = 0; i < wr_q.size() - wr_base; i++)
         if (wr_q[wr_base + i] !== AW'(i)) mism++;
      checkOutput({name, ".wr_order"}, mism, 0);
      checkOutput({name, ".wr_data"}, wdata_err_total - wdata_base, 0);
      checkOutput({name, ".stable"}, stab_err_total - stab_base, 0);
      checkOutput({name, ".valid_seen"}, (valid_total - valid_base) > 0, n_exp > 0);
      mism = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_img[i]) mism++;
      checkOutput({name, ".buffer"}, mism, 0);
   endtask

   initial begin
      logic got;
      reset       = 1'b1;
      start       = 1'b0;
      scan_len    = '0;
      clear_en    = 1'b0;
      pa_we       = 1'b0;
      pa_clr      = 1'b0;
      pa_addr     = '0;
      pa_data     = '0;
      ready_mode  = 0;
      ready_fixed = 1'b0;

      $display("[TB] reset state");
      repeat (3) @(posedge clk);
      #1;
      clearBuffer();
      @(negedge clk);
      checkOutput("rst.busy", busy, 0);
      checkOutput("rst.done", done, 0);
      checkOutput("rst.mem_wr", bus.mem_wr, 0);
      checkOutput("rst.mem_addr", bus.mem_addr, 0);
      checkOutput("rst.mem_wr_data", bus.mem_wr_data, 0);
      checkOutput("rst.coll_valid", bus.coll_valid, 0);
      checkOutput("rst.coll_addr", bus.coll_addr, 0);
      checkOutput("rst.coll_id", bus.coll_id, 0);
      checkOutput("rst.coll_count", coll_count, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      $display("[TB] reset while a record is pending");
      fillEntry(2, 9'h1AA);
      fillEntry(5, 9'h103);
      ready_fixed = 1'b1;
      applyStimulus(1024, 1'b1);
      got = 1'b0;
      for (int n = 0; n < 100 && !got; n++) begin
         @(negedge clk);
         if (coll_count == CW'(1)) got = 1'b1;
      end
      checkOutput("abort.first_accept", got, 1);
      ready_fixed = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 100 && !got; n++) begin
         @(negedge clk);
         if (bus.coll_valid === 1'b1) got = 1'b1;
      end
      checkOutput("abort.valid_seen", got, 1);
      repeat (2) @(negedge clk);
      checkOutput("abort.valid_held", bus.coll_valid, 1);
      #2;
      reset = 1'b1;
      @(negedge clk);
      checkOutput("abort.busy", busy, 0);
      checkOutput("abort.coll_valid", bus.coll_valid, 0);
      checkOutput("abort.mem_wr", bus.mem_wr, 0);
      checkOutput("abort.coll_count", coll_count, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      ready_fixed = 1'b1;
      applyStimulus(1024, 1'b1);
      waitDone("rerun", 20000);
      checkScan("rerun");

      $display("[TB] clean full-depth scan");
      clearBuffer();
      applyStimulus(1024, 1'b1);
      waitDone("clean", 20000);
      checkScan("clean");
      checkOutput("clean.latency", done_cyc - t_start, 2049);

      $display("[TB] two flagged entries, one unflagged id");
      clearBuffer();
      fillEntry(5, 9'h103);
      fillEntry(1023, 9'h1FF);
      fillEntry(7, 9'h044);
      applyStimulus(1024, 1'b1);
      waitDone("pair", 20000);
      checkScan("pair");

      $display("[TB] first record stalled ten cycles");
      clearBuffer();
      fillEntry(5, 9'h103);
      fillEntry(1023, 9'h1FF);
      fillEntry(7, 9'h044);
      ready_fixed = 1'b0;
      applyStimulus(1024, 1'b1);
      got = 1'b0;
      for (int n = 0; n < 100 && !got; n++) begin
         @(negedge clk);
         if (bus.coll_valid === 1'b1) got = 1'b1;
      end
      checkOutput("stall.valid_seen", got, 1);
      repeat (9) @(negedge clk);
      ready_fixed = 1'b1;
      waitDone("stall", 20000);
      checkScan("stall");
      checkOutput("stall.cycles", stall_total - stall_base, 10);

      $display("[TB] zero-length scan");
      fillEntry(0, 9'h1C3);
      applyStimulus(0, 1'b1);
      waitDone("zero", 100);
      checkScan("zero");

      $display("[TB] oversize length request");
      clearBuffer();
      fillEntry(0, 9'h101);
      fillEntry(1023, 9'h1FF);
      fillRandom(20);
      applyStimulus(2000, 1'b1);
      waitDone("clamp", 20000);
      checkScan("clamp");

      $display("[TB] scan without clearing");
      clearBuffer();
      fillRandom(40);
      ready_mode = 1;
      applyStimulus(1024, 1'b0);
      waitDone("noclr", 20000);
      checkScan("noclr");

      $display("[TB] counter saturation");
      clearBuffer();
      for (int i = 0; i < 300; i++) fillEntry(i, {1'b1, 8'($urandom)});
      applyStimulus(1024, 1'b1);
      waitDone("sat", 20000);
      checkScan("sat");
      checkOutput("sat.value", coll_count, CMAX);

      $display("[TB] start while busy");
      clearBuffer();
      fillRandom(30);
      applyStimulus(1024, 1'b1);
      repeat (40) @(posedge clk);
      #1;
      start    = 1'b1;
      scan_len = (AW + 1)'(5);
      clear_en = 1'b0;
      @(posedge clk);
      #1;
      start    = 1'b0;
      waitDone("restart", 20000);
      checkScan("restart");

      $display("[TB] random scans");
      for (int r = 0; r < 4; r++) begin
         fillRandom($urandom_range(10, 60));
         applyStimulus($urandom_range(0, 1100), 1'($urandom_range(0, 1)));
         waitDone("rand", 20000);
         checkScan("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
